// File: rtl/serial_avg_pkg.sv
// Shared types and helpers for the serial frame averager.
package serial_avg_pkg;

    typedef enum logic {ST_ACC, ST_HOLD} state_t;

    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_HALF_UP = 1;

    function automatic int acc_width(input int w, input int log_n);
        return w + log_n;
    endfunction

endpackage

// File: rtl/avg_abs_diff.sv
// Combinational tail of a frame: final sum, rounded average and |avg - last sample|.
module avg_abs_diff
    import serial_avg_pkg::*;
#(
    parameter int W     = 8,
    parameter int LOG_N = 2,
    localparam int AW   = acc_width(W, LOG_N)
) (
    input  logic [AW-1:0] acc,
    input  logic [W-1:0]  ser_in,
    input  logic [AW-1:0] rnd,
    output logic [W-1:0]  avg,
    output logic [W-1:0]  diff
);

    logic [AW-1:0] sum;

    // The rounded sum cannot exceed N*2**W - 1, so the shifted value always fits in W bits.
    assign sum  = acc + AW'(ser_in);
    assign avg  = W'((sum + rnd) >> LOG_N);
    assign diff = (avg >= ser_in) ? avg - ser_in : ser_in - avg;

endmodule

// File: rtl/serial_avg_diff.sv
// Streaming frame averager: sums 2**LOG_N samples, then holds average and |average - last| until taken.
module serial_avg_diff
    import serial_avg_pkg::*;
#(
    parameter int W     = 8,
    parameter int LOG_N = 2,
    parameter int ROUND = ROUND_TRUNC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic [W-1:0] ser_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] avg_out,
    output logic [W-1:0] diff_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         done
);

    localparam int AW = acc_width(W, LOG_N);
    localparam int CW = (LOG_N > 0) ? LOG_N : 1;
    localparam logic [CW-1:0] LAST = CW'((1 << LOG_N) - 1);

    function automatic logic [AW-1:0] round_term();
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < AW; i++) begin
            if (ROUND == ROUND_HALF_UP && i == LOG_N - 1) r[i] = 1'b1;
        end
        return r;
    endfunction

    state_t         state;
    logic [CW-1:0]  count;
    logic [AW-1:0]  acc;
    logic [AW-1:0]  acc_base;
    logic [W-1:0]   avg;
    logic [W-1:0]   diff;
    logic           last;

    // The first sample of a frame loads the accumulator rather than adding to it.
    assign acc_base = (count == '0) ? '0 : acc;
    assign last     = (count == LAST);

    avg_abs_diff #(
        .W     (W),
        .LOG_N (LOG_N)
    ) u_avg_abs_diff (
        .acc    (acc_base),
        .ser_in (ser_in),
        .rnd    (round_term()),
        .avg    (avg),
        .diff   (diff)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_ACC;
            count    <= '0;
            acc      <= '0;
            avg_out  <= '0;
            diff_out <= '0;
        end else if (clear) begin
            state <= ST_ACC;
            count <= '0;
            acc   <= '0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (in_valid) begin
                        if (last) begin
                            avg_out  <= avg;
                            diff_out <= diff;
                            state    <= ST_HOLD;
                            count    <= '0;
                            acc      <= '0;
                        end else begin
                            acc   <= acc_base + AW'(ser_in);
                            count <= count + CW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) state <= ST_ACC;
                end
                default: state <= ST_ACC;
            endcase
        end
    end

    assign in_ready  = (state == ST_ACC);
    assign out_valid = (state == ST_HOLD);
    assign done      = (state == ST_ACC) && (count == '0);

endmodule
